button_press_arbiter: RTL

- Front-end controller that sequences raw pushbutton inputs into the clean single-cycle commands consumed by the buttons control FSM (btncZ/btnlZ/btnrZ).
- Each of the three buttons is synchronized and debounced. Simultaneous presses are arbitrated by fixed priority.
- At most one command pulse is emitted per press episode; the next pulse requires all buttons to be released.
- Sits between the board button pins and the buttons control FSM, in the same clock domain.

---
 rtl/button_press_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/button_press_arbiter.sv
// Pushbutton front end: 2-flop sync and debounce per button, C > L > R grant, one command pulse per press episode.
// Defining BTN_AUTO_REPEAT_EN adds auto-repeat of a lone held L or R button.
module button_press_arbiter #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnc,
  input  logic       btnl,
  input  logic       btnr,
  output logic       btncZ,
  output logic       btnlZ,
  output logic       btnrZ,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       collision
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  // Bit order everywhere: [0]=C, [1]=L, [2]=R.
  logic [2:0]       raw;
  logic [2:0]       meta_q, sync_q;
  logic [2:0]       deb_q, deb_d, deb_prev_q;
  logic [2:0]       new_x, new_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [2:0] win;
  logic [1:0] win_id;
  logic       multi;
  logic [2:0] grant_pulse;
  logic [2:0] rep_pulse;

  assign raw   = {btnr, btnl, btnc};
  assign new_x = deb_q & ~deb_prev_q;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      new_q      <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      new_q      <= new_x;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    win    = 3'b000;
    win_id = 2'b00;
    if (new_q[0]) begin
      win    = 3'b001;
      win_id = 2'b01;
    end else if (new_q[1]) begin
      win    = 3'b010;
      win_id = 2'b10;
    end else if (new_q[2]) begin
      win    = 3'b100;
      win_id = 2'b11;
    end
  end

  assign multi = (new_q[0] & new_q[1]) | (new_q[0] & new_q[2]) | (new_q[1] & new_q[2]);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    grant_id_d  = grant_id_q;
    grant_pulse = 3'b000;
    busy        = 1'b0;
    collision   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|new_q) begin
          state_d    = GRANT;
          sel_d      = win;
          grant_id_d = win_id;
          collision  = multi;
        end
      end
      GRANT: begin
        grant_pulse = sel_q;
        state_d     = WAIT_REL;
      end
      WAIT_REL: begin
        busy = 1'b1;
        if (deb_q == 3'b000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_fire_q, rep_fire_d;
  logic          rep_hold;

  // Only the granted L/R button held alone keeps the repeat timer running.
  assign rep_hold = (state_q == WAIT_REL) && !sel_q[0] && (deb_q == sel_q);

  always_comb begin
    rep_d      = '0;
    rep_fire_d = 1'b0;
    if (rep_hold) begin
      if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
        rep_fire_d = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q      <= '0;
      rep_fire_q <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      rep_fire_q <= rep_fire_d;
    end
  end

  assign rep_pulse = (rep_fire_q && (state_q == WAIT_REL)) ? sel_q : 3'b000;
`else
  assign rep_pulse = 3'b000;
`endif

  assign {btnrZ, btnlZ, btncZ} = grant_pulse | rep_pulse;
  assign grant_id              = grant_id_q;

endmodule
